// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache controller.
// The cache attaches through the slave modport; the CPU/memory environment uses master.
interface dcache_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [WORD_SIZE-1:0]  cpu_addr;
    logic [WORD_SIZE-1:0]  cpu_wdata;
    logic [WORD_SIZE-1:0]  cpu_rdata;
    logic                  cpu_ready;
    logic                  flush_req;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [BLOCK_SIZE-1:0] mem_wdata;
    logic [BLOCK_SIZE-1:0] mem_rdata1;
    logic [BLOCK_SIZE-1:0] mem_rdata2;
    logic                  mem_flush;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata1, mem_rdata2,
        output cpu_rdata, cpu_ready, mem_addr, mem_read, mem_write, mem_wdata, mem_flush
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata1, mem_rdata2,
        input  cpu_rdata, cpu_ready, mem_addr, mem_read, mem_write, mem_wdata, mem_flush
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: one word per access, whole-line
// refill/writeback, and a flush sequence that drains dirty lines then raises mem_flush.
module dcache_ctrl #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024,
    parameter int LINES      = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    dcache_if.slave bus
);
    localparam int LINE_BITS = $clog2(BLOCK_SIZE / 8);
    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_W     = WORD_SIZE - IDX_W - LINE_BITS;
    localparam int BYTE_BITS = $clog2(WORD_SIZE / 8);
    localparam int OFF_W     = LINE_BITS - BYTE_BITS;
    localparam int WSEL_W    = $clog2(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE, COMPARE, WB, FILL, WAIT, RESP, FL_SCAN, FL_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      scan_q, scan_d;
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    logic [OFF_W-1:0]      req_off_q, req_off_d;
    logic                  req_we_q, req_we_d;
    logic [WORD_SIZE-1:0]  req_wdata_q, req_wdata_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [WORD_SIZE-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [WORD_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [BLOCK_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_flush_q, mem_flush_d;

    logic [BLOCK_SIZE-1:0] data_q [LINES];
    logic [TAG_W-1:0]      tag_q  [LINES];

    logic                  hit;
    logic [WSEL_W-1:0]     wsel;
    logic                  unused_bits;

    assign unused_bits = ^{bus.cpu_addr[BYTE_BITS-1:0], bus.mem_rdata2};

    // Big-endian: word w sits at bit (WORDS-1-w)*WORD_SIZE, i.e. the inverted offset.
    assign wsel = {~req_off_q, {(WSEL_W - OFF_W){1'b0}}};
    assign hit  = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_off_d   = req_off_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = FL_SCAN;
                    scan_d  = '0;
                end else if (bus.cpu_req) begin
                    req_tag_d   = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
                    req_idx_d   = bus.cpu_addr[LINE_BITS +: IDX_W];
                    req_off_d   = bus.cpu_addr[BYTE_BITS +: OFF_W];
                    req_we_d    = bus.cpu_we;
                    req_wdata_d = bus.cpu_wdata;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (req_we_q) dirty_d[req_idx_q] = 1'b1;
                    else          cpu_rdata_d = data_q[req_idx_q][wsel +: WORD_SIZE];
                    state_d = RESP;
                end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB: begin
                dirty_d[req_idx_q] = 1'b0;
                state_d            = FILL;
            end
            FILL: state_d = WAIT;
            WAIT: begin
                valid_d[req_idx_q] = 1'b1;
                dirty_d[req_idx_q] = 1'b0;
                state_d            = COMPARE;
            end
            RESP: state_d = IDLE;
            FL_SCAN: begin
                dirty_d[scan_q] = 1'b0;
                if (scan_q == IDX_W'(LINES - 1)) state_d = FL_DONE;
                else                             scan_d  = scan_q + 1'b1;
            end
            FL_DONE: state_d = FL_DONE;
            default: state_d = IDLE;
        endcase

        // Memory strobes are computed for the state being entered so each one is high
        // exactly during that state's cycle; cpu_ready trails RESP by one cycle.
        mem_read_d = (state_d == FILL);
        if (state_d == WB) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[req_idx_q], req_idx_q, {LINE_BITS{1'b0}}};
            mem_wdata_d = data_q[req_idx_q];
        end else if (state_d == FILL) begin
            mem_addr_d  = {req_tag_q, req_idx_q, {LINE_BITS{1'b0}}};
        end else if (state_d == FL_SCAN && valid_q[scan_d] && dirty_q[scan_d]) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[scan_d], scan_d, {LINE_BITS{1'b0}}};
            mem_wdata_d = data_q[scan_d];
        end
        cpu_ready_d = (state_q == RESP);
        mem_flush_d = (state_d == FL_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_off_q   <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_off_q   <= req_off_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            mem_flush_q <= mem_flush_d;
        end
    end

    // Line storage is not reset; valid bits alone decide whether contents are trusted.
    always_ff @(posedge clk) begin
        if (state_q == WAIT) begin
            data_q[req_idx_q] <= bus.mem_rdata1;
            tag_q[req_idx_q]  <= req_tag_q;
        end else if (state_q == COMPARE && hit && req_we_q) begin
            data_q[req_idx_q][wsel +: WORD_SIZE] <= req_wdata_q;
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_flush = mem_flush_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised bench for dcache_ctrl against a byte-level cache/memory reference model.
module tb_dcache_ctrl;
    localparam int WS = 32;
    localparam int BS = 1024;
    localparam int LN = 4;
    localparam int LB = BS / 8;
    typedef logic [BS-1:0] val_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) bus ();
    dcache_ctrl #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .LINES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input val_t got, input val_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment memory: byte[a] = a[7:0] until written by the cache.
    logic [7:0]    emem [logic [31:0]];
    logic [WS-1:0] rd_q [$];
    logic [WS-1:0] wa_q [$];
    val_t          wd_q [$];

    function automatic logic [7:0] ebyte(input logic [31:0] a);
        return emem.exists(a) ? emem[a] : a[7:0];
    endfunction

    function automatic val_t env_block(input logic [31:0] base);
        val_t b;
        for (int i = 0; i < LB; i++) b[BS-1-8*i -: 8] = ebyte(base + 32'(i));
        return b;
    endfunction

    always @(posedge clk)
        if (bus.mem_read) bus.mem_rdata1 <= env_block(bus.mem_addr);

    always @(negedge clk) begin
        check("rw_excl", val_t'(bus.mem_read & bus.mem_write), val_t'(0));
        if (rst_n && bus.mem_read) rd_q.push_back(bus.mem_addr);
        if (rst_n && bus.mem_write) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            for (int i = 0; i < LB; i++) emem[bus.mem_addr + 32'(i)] = bus.mem_wdata[BS-1-8*i -: 8];
        end
    end

    // Reference model: per-line valid/dirty/tag and byte contents, plus its own memory image.
    logic        mv [LN];
    logic        md [LN];
    logic [22:0] mt [LN];
    logic [7:0]  mc [LN][LB];
    logic [7:0]  mmem [logic [31:0]];

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : a[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LN; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    function automatic val_t line_block(input int idx);
        val_t b;
        for (int i = 0; i < LB; i++) b[BS-1-8*i -: 8] = mc[idx][i];
        return b;
    endfunction

    task automatic clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.flush_req = 1'b0;
        #1;
        check("reset_ctl", val_t'({bus.cpu_ready, bus.mem_read, bus.mem_write, bus.mem_flush,
                                   bus.mem_addr, bus.cpu_rdata}), val_t'(0));
        check("reset_wdata", bus.mem_wdata, val_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata);
        logic [1:0]  idx;
        logic [22:0] tag;
        logic [31:0] base, wb_addr, exp_rd;
        val_t        wb_data;
        int          off, exp_lat, n;
        bit          hit, wb, got;
        idx  = addr[8:7];
        tag  = addr[31:9];
        base = {addr[31:7], 7'b0};
        off  = int'(addr[6:2]) * 4;
        hit  = mv[idx] && mt[idx] == tag;
        wb   = !hit && mv[idx] && md[idx];
        exp_lat = hit ? 2 : (wb ? 6 : 5);
        wb_addr = {mt[idx], idx, 7'b0};
        wb_data = line_block(int'(idx));
        exp_rd  = '0;
        if (wb)
            for (int i = 0; i < LB; i++) mmem[wb_addr + 32'(i)] = mc[idx][i];
        if (!hit) begin
            for (int i = 0; i < LB; i++) mc[idx][i] = mbyte(base + 32'(i));
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mt[idx] = tag;
        end
        if (we) begin
            for (int k = 0; k < 4; k++) mc[idx][off+k] = wd[31-8*k -: 8];
            md[idx] = 1'b1;
        end else begin
            exp_rd = {mc[idx][off], mc[idx][off+1], mc[idx][off+2], mc[idx][off+3]};
        end

        @(negedge clk);
        clear_logs();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.cpu_ready) got = 1'b1;
        end
        check("latency", val_t'(n), val_t'(exp_lat));
        if (!we) check("rdata", val_t'(bus.cpu_rdata), val_t'(exp_rd));
        check("rd_count", val_t'(rd_q.size()), val_t'(hit ? 0 : 1));
        if (!hit && rd_q.size() > 0) check("rd_addr", val_t'(rd_q[0]), val_t'(base));
        check("wr_count", val_t'(wa_q.size()), val_t'(wb));
        if (wb && wa_q.size() > 0) begin
            check("wb_addr", val_t'(wa_q[0]), val_t'(wb_addr));
            check("wb_data", wd_q[0], wb_data);
        end
        rdata = bus.cpu_rdata;
    endtask

    task automatic do_flush(input bit with_req);
        logic [31:0] exp_a [$];
        val_t        exp_d [$];
        int          n, readies, nwr;
        for (int i = 0; i < LN; i++) begin
            if (mv[i] && md[i]) begin
                exp_a.push_back({mt[i], 2'(i), 7'b0});
                exp_d.push_back(line_block(i));
                for (int b = 0; b < LB; b++) mmem[{mt[i], 2'(i), 7'b0} + 32'(b)] = mc[i][b];
                md[i] = 1'b0;
            end
        end
        @(negedge clk);
        clear_logs();
        bus.flush_req = 1'b1;
        bus.cpu_req   = with_req;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h84;
        @(posedge clk);
        #1;
        bus.flush_req = 1'b0;
        bus.cpu_req   = 1'b0;
        n       = 0;
        readies = 0;
        while (n < 20 && !bus.mem_flush) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.cpu_ready) readies++;
        end
        check("flush_lat", val_t'(n), val_t'(LN));
        check("flush_wr_count", val_t'(wa_q.size()), val_t'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
            check("flush_wr_addr", val_t'(wa_q[i]), val_t'(exp_a[i]));
            check("flush_wr_data", wd_q[i], exp_d[i]);
        end
        nwr = wa_q.size();
        bus.cpu_req   = 1'b1;
        bus.flush_req = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.cpu_ready) readies++;
        end
        bus.cpu_req   = 1'b0;
        bus.flush_req = 1'b0;
        check("flush_hold", val_t'(bus.mem_flush), val_t'(1));
        check("flush_no_ready", val_t'(readies), val_t'(0));
        check("flush_quiet", val_t'(rd_q.size() + wa_q.size() - nwr), val_t'(0));
    endtask

    initial begin
        logic [31:0] rd;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.flush_req  = 1'b0;
        bus.mem_rdata1 = '0;
        bus.mem_rdata2 = '0;
        model_reset();
        do_reset();

        access(1'b0, 32'h84, 32'h0, rd);
        check("load_84", val_t'(rd), val_t'(32'h84858687));
        access(1'b0, 32'h88, 32'h0, rd);
        check("load_88", val_t'(rd), val_t'(32'h88898A8B));
        access(1'b1, 32'h84, 32'hDEADBEEF, rd);
        access(1'b0, 32'h284, 32'h0, rd);
        check("load_284", val_t'(rd), val_t'(32'h84858687));
        access(1'b0, 32'h84, 32'h0, rd);
        check("reload_84", val_t'(rd), val_t'(32'hDEADBEEF));

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 7)
              | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, rd);
        end
        do_flush(1'b0);

        do_reset();
        access(1'b1, 32'h000, 32'h11223344, rd);
        access(1'b1, 32'h104, 32'h55667788, rd);
        access(1'b0, 32'h080, 32'h0, rd);
        do_flush(1'b0);

        // Reset while the refill is outstanding, then the same load must miss again.
        do_reset();
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h184;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(posedge clk);
        #1 check("fill_read", val_t'(bus.mem_read), val_t'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("midwait_reset", val_t'({bus.mem_read, bus.cpu_ready, bus.mem_addr}), val_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        access(1'b0, 32'h184, 32'h0, rd);
        check("load_184", val_t'(rd), val_t'(32'h84858687));

        do_reset();
        access(1'b1, 32'h300, 32'hCAFEF00D, rd);
        do_flush(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
